// File: rtl/mem_arbiter_multi.sv
// mem_arbiter_multi: arbitrates the shared instruction/data memory between the CPU and a debug/DMA master.
// Round-robin by default; define MEMARB_CPU_PRIORITY_EN for fixed CPU-over-debug priority.
module mem_arbiter_multi #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCpuRead,
    input  logic              iCpuWrite,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuWData,
    output logic [DATA_W-1:0] oCpuRData,
    output logic              oCpuReady,
    output logic              oCpuStall,
    input  logic              iDbgReq,
    input  logic              iDbgWe,
    input  logic [ADDR_W-1:0] iDbgAddr,
    input  logic [DATA_W-1:0] iDbgWData,
    output logic [DATA_W-1:0] oDbgRData,
    output logic              oDbgAck,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemRead,
    output logic              oMemWrite,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [1:0]        oArbState
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CPU_BUSY = 2'd1;
    localparam logic [1:0] DBG_BUSY = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_req, busy, done, grant_cpu, grant_dbg, capture;

    // owner/last encoding: 0 = CPU, 1 = debug
    assign cpu_req = iCpuRead | iCpuWrite;
    assign busy    = (state_q == CPU_BUSY) | (state_q == DBG_BUSY);
    assign done    = state_q == DONE;
    assign capture = busy & (cnt_q == LAST_CNT);
`ifdef MEMARB_CPU_PRIORITY_EN
    assign grant_cpu = cpu_req;
`else
    assign grant_cpu = cpu_req & (~iDbgReq | last_q);
`endif
    assign grant_dbg = iDbgReq & ~grant_cpu;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        if (state_q == IDLE && (grant_cpu | grant_dbg)) begin
            state_d = grant_cpu ? CPU_BUSY : DBG_BUSY;
            cnt_d   = '0;
            owner_d = grant_dbg;
            we_d    = grant_cpu ? iCpuWrite : iDbgWe;
            addr_d  = grant_cpu ? iCpuAddr : iDbgAddr;
            wdata_d = grant_cpu ? iCpuWData : iDbgWData;
        end else if (busy) begin
            cnt_d       = cnt_q + 4'd1;
            state_d     = capture ? DONE : state_q;
            cpu_rdata_d = capture & ~we_q & ~owner_q ? iMemRData : cpu_rdata_q;
            dbg_rdata_d = capture & ~we_q & owner_q ? iMemRData : dbg_rdata_q;
        end else if (done) begin
            state_d = IDLE;
            last_d  = owner_q;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // strobes decode straight from state so an async reset drops them at once
    assign oMemRead  = busy & ~we_q;
    assign oMemWrite = busy & we_q;
    assign oMemAddr  = addr_q;
    assign oMemWData = wdata_q;
    assign oCpuReady = done & ~owner_q;
    assign oDbgAck   = done & owner_q;
    assign oCpuStall = cpu_req & ~(done & ~owner_q);
    assign oCpuRData = cpu_rdata_q;
    assign oDbgRData = dbg_rdata_q;
    assign oArbState = state_q;
endmodule

// File: tb/tb_mem_arbiter_multi.sv
// tb_mem_arbiter_multi: directed and random checks of mem_arbiter_multi against a transaction-level model.
module tb_mem_arbiter_multi;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iCpuRead, iCpuWrite, iDbgReq, iDbgWe;
    logic [AW-1:0] iCpuAddr, iDbgAddr;
    logic [DW-1:0] iCpuWData, iDbgWData, iMemRData;
    logic [DW-1:0] oCpuRData, oDbgRData, oMemWData;
    logic [AW-1:0] oMemAddr;
    logic          oCpuReady, oCpuStall, oDbgAck, oMemRead, oMemWrite;
    logic [1:0]    oArbState;

    int total = 0;
    int bad   = 0;

    int            m_left;
    bit            m_own, m_we, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_crd, m_drd;
    bit            done_seq[$];

    always #5 iCLK = ~iCLK;

    mem_arbiter_multi #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCpuRead(iCpuRead), .iCpuWrite(iCpuWrite), .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
        .oCpuRData(oCpuRData), .oCpuReady(oCpuReady), .oCpuStall(oCpuStall),
        .iDbgReq(iDbgReq), .iDbgWe(iDbgWe), .iDbgAddr(iDbgAddr), .iDbgWData(iDbgWData),
        .oDbgRData(oDbgRData), .oDbgAck(oDbgAck),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .iMemRData(iMemRData), .oArbState(oArbState)
    );

    task automatic m_reset();
        m_left = 0;
        m_own  = 0;
        m_we   = 0;
        m_last = 1;
        m_addr = '0;
        m_wd   = '0;
        m_crd  = '0;
        m_drd  = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] a, input logic [63:0] e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, a, e);
        end
    endtask

    // m_left counts the cycles an access still occupies: LAT strobe cycles then one completion cycle
    task automatic cyc();
        bit cr, dr, gc, strobe, fin;
        #1;
        if (iRST) m_reset();
        strobe = m_left > 1;
        fin    = m_left == 1;
        chk("mem_read", oMemRead, strobe && !m_we);
        chk("mem_write", oMemWrite, strobe && m_we);
        chk("mem_addr", oMemAddr, m_addr);
        chk("mem_wdata", oMemWData, m_wd);
        chk("cpu_ready", oCpuReady, fin && !m_own);
        chk("dbg_ack", oDbgAck, fin && m_own);
        chk("cpu_rdata", oCpuRData, m_crd);
        chk("dbg_rdata", oDbgRData, m_drd);
        chk("cpu_stall", oCpuStall, (iCpuRead || iCpuWrite) && !(fin && !m_own));
        chk("arb_state", oArbState, m_left == 0 ? 0 : fin ? 3 : m_own ? 2 : 1);
        if (oCpuReady) done_seq.push_back(1'b0);
        if (oDbgAck) done_seq.push_back(1'b1);
        if (!iRST) begin
            if (m_left == 0) begin
                cr = iCpuRead || iCpuWrite;
                dr = iDbgReq;
`ifdef MEMARB_CPU_PRIORITY_EN
                gc = cr;
`else
                gc = cr && (!dr || m_last);
`endif
                if (gc || dr) begin
                    m_own  = !gc;
                    m_left = LAT + 1;
                    m_we   = gc ? iCpuWrite : iDbgWe;
                    m_addr = gc ? iCpuAddr : iDbgAddr;
                    m_wd   = gc ? iCpuWData : iDbgWData;
                end
            end else begin
                if (m_left == 2 && !m_we) begin
                    if (m_own) m_drd = iMemRData;
                    else m_crd = iMemRData;
                end
                if (m_left == 1) m_last = m_own;
                m_left--;
            end
        end
        @(negedge iCLK);
    endtask

    initial begin
        iRST = 1; iCpuRead = 0; iCpuWrite = 0; iDbgReq = 0; iDbgWe = 0;
        iCpuAddr = '0; iDbgAddr = '0; iCpuWData = '0; iDbgWData = '0; iMemRData = '0;
        m_reset();
        @(negedge iCLK);
        repeat (2) cyc();
        iRST = 0;
        cyc();
        // CPU read
        iCpuRead = 1; iCpuAddr = 'h10; iMemRData = 'hDEADBEEF;
        #1 chk("t1_stall_t0", oCpuStall, 1);
        cyc();
        #1 chk("t1_read_t1", oMemRead, 1);
        cyc();
        #1 chk("t1_read_t2", oMemRead, 1);
        chk("t1_stall_t2", oCpuStall, 1);
        cyc();
        #1 chk("t1_ready", oCpuReady, 1);
        chk("t1_rdata", oCpuRData, 'hDEADBEEF);
        chk("t1_stall_t3", oCpuStall, 0);
        iCpuRead = 0;
        cyc(); cyc();
        // CPU write
        iCpuWrite = 1; iCpuAddr = 'h20; iCpuWData = 'h12345678; iMemRData = 'h0BADF00D;
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1 chk("t2_write", oMemWrite, 1);
            chk("t2_addr", oMemAddr, 'h20);
            chk("t2_wdata", oMemWData, 'h12345678);
            cyc();
        end
        #1 chk("t2_ready", oCpuReady, 1);
        chk("t2_rdata_kept", oCpuRData, 'hDEADBEEF);
        iCpuWrite = 0;
        cyc(); cyc();
        // both held from reset
        iRST = 1;
        cyc();
        iRST = 0; iCpuRead = 1; iCpuAddr = 'h30; iDbgReq = 1; iDbgWe = 1; iDbgAddr = 'h40; iDbgWData = 'h55AA55AA;
        done_seq.delete();
        repeat (16) cyc();
        chk("t3_count", done_seq.size(), 4);
        for (int i = 0; i < 4 && i < done_seq.size(); i++)
`ifdef MEMARB_CPU_PRIORITY_EN
            chk("t3_owner", done_seq[i], 0);
`else
            chk("t3_owner", done_seq[i], i % 2);
`endif
        // CPU releases; debug is next
        iCpuRead = 0;
        repeat (3) cyc();
        #1 chk("t6_dbg_ack", oDbgAck, 1);
        iDbgReq = 0;
        cyc(); cyc();
        chk("t6_count", done_seq.size(), 5);
        if (done_seq.size() == 5) chk("t6_last", done_seq[4], 1);
        // reset during debug access
        done_seq.delete();
        iDbgReq = 1; iDbgWe = 0; iDbgAddr = 'h50;
        cyc();
        #1 chk("t4_read_before", oMemRead, 1);
        iRST = 1;
        #1 chk("t4_read_drop", oMemRead, 0);
        chk("t4_state", oArbState, 0);
        cyc();
        iRST = 0; iCpuRead = 1; iCpuAddr = 'h60; iMemRData = 'h600D0060;
        repeat (3) cyc();
        #1 chk("t4_cpu_first", oCpuReady, 1);
        iCpuRead = 0; iDbgReq = 0;
        cyc(); cyc();
        chk("t4_count", done_seq.size(), 1);
        if (done_seq.size() == 1) chk("t4_owner", done_seq[0], 0);
        // debug drops request mid-access
        done_seq.delete();
        iDbgReq = 1; iDbgWe = 0; iDbgAddr = 'h70; iMemRData = 'hCAFE0005;
        cyc();
        iDbgReq = 0; iDbgWe = 1;
        cyc(); cyc();
        #1 chk("t5_ack", oDbgAck, 1);
        chk("t5_rdata", oDbgRData, 'hCAFE0005);
        repeat (4) cyc();
        chk("t5_count", done_seq.size(), 1);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            iMemRData = $urandom;
            if (m_left == 1 && !m_own) begin
                iCpuRead = 0; iCpuWrite = 0;
            end else if (!(iCpuRead || iCpuWrite) && $urandom_range(3) == 0) begin
                iCpuWrite = 1'($urandom_range(1));
                iCpuRead = !iCpuWrite || 1'($urandom_range(1));
                iCpuAddr = $urandom; iCpuWData = $urandom;
            end
            if (m_left == 1 && m_own) iDbgReq = 0;
            else if (iDbgReq && m_left > 1 && m_own && $urandom_range(7) == 0) iDbgReq = 0;
            else if (!iDbgReq && $urandom_range(3) == 0) begin
                iDbgReq = 1; iDbgWe = 1'($urandom_range(1));
                iDbgAddr = $urandom; iDbgWData = $urandom;
            end
            if (!iDbgReq) begin
                iDbgWe = 1'($urandom_range(1)); iDbgAddr = $urandom;
            end
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
